// File: rtl/mio_pkg.sv
// Shared MIO definitions: blit engine states, address-region nibbles and screen geometry.
package mio_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_RD,
        S_WR,
        S_ADV,
        S_DONE
    } blit_state_e;

    localparam logic [3:0] REGION_RAM    = 4'h0;
    localparam logic [3:0] REGION_PICEND = 4'hB;
    localparam logic [3:0] REGION_VRAM   = 4'hC;
    localparam logic [3:0] REGION_KBD    = 4'hD;
    localparam logic [3:0] REGION_SSEG   = 4'hE;
    localparam logic [3:0] REGION_PIO    = 4'hF;

    localparam int PITCH_DEF = 640;
    localparam int SCREEN_H  = 480;
    localparam int PIX_W     = 19;

endpackage

// File: rtl/mio_blit_addr_gen.sv
// Block-walk address generator: x/y counters, row-start and current pixel pointers.
// The 19-bit pixel index wraps naturally; the upper address bits are frozen at load.
module mio_blit_addr_gen
    import mio_pkg::*;
#(
    parameter int SRC_PITCH = PITCH_DEF,
    parameter int DST_PITCH = PITCH_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        step,
    input  logic [31:0] src_base,
    input  logic [31:0] dst_base,
    input  logic [9:0]  blk_w,
    input  logic [8:0]  blk_h,
    output logic [31:0] src_ptr,
    output logic [31:0] dst_ptr,
    output logic        last
);

    logic [12:0]      src_hi_q, src_hi_d, dst_hi_q, dst_hi_d;
    logic [PIX_W-1:0] src_row_q, src_row_d, dst_row_q, dst_row_d;
    logic [PIX_W-1:0] src_cur_q, src_cur_d, dst_cur_q, dst_cur_d;
    logic [9:0]       w_q, w_d, x_q, x_d;
    logic [8:0]       h_q, h_d, y_q, y_d;
    logic             last_q, last_d;
    logic             end_of_row;

    assign end_of_row = (x_q == w_q - 10'd1);

    always_comb begin
        src_hi_d  = src_hi_q;
        dst_hi_d  = dst_hi_q;
        src_row_d = src_row_q;
        dst_row_d = dst_row_q;
        src_cur_d = src_cur_q;
        dst_cur_d = dst_cur_q;
        w_d       = w_q;
        h_d       = h_q;
        x_d       = x_q;
        y_d       = y_q;
        last_d    = last_q;
        if (load) begin
            src_hi_d  = src_base[31:19];
            dst_hi_d  = dst_base[31:19];
            src_row_d = src_base[18:0];
            dst_row_d = dst_base[18:0];
            src_cur_d = src_base[18:0];
            dst_cur_d = dst_base[18:0];
            w_d       = blk_w;
            h_d       = blk_h;
            x_d       = '0;
            y_d       = '0;
            last_d    = 1'b0;
        end else if (step) begin
            if (end_of_row) begin
                // New row: both row starts move down one pitch, no multiply needed.
                x_d       = '0;
                y_d       = y_q + 9'd1;
                src_row_d = src_row_q + PIX_W'(SRC_PITCH);
                dst_row_d = dst_row_q + PIX_W'(DST_PITCH);
                src_cur_d = src_row_q + PIX_W'(SRC_PITCH);
                dst_cur_d = dst_row_q + PIX_W'(DST_PITCH);
                last_d    = (y_q == h_q - 9'd1);
            end else begin
                x_d       = x_q + 10'd1;
                src_cur_d = src_cur_q + 19'd1;
                dst_cur_d = dst_cur_q + 19'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            src_hi_q  <= '0;
            dst_hi_q  <= '0;
            src_row_q <= '0;
            dst_row_q <= '0;
            src_cur_q <= '0;
            dst_cur_q <= '0;
            w_q       <= '0;
            h_q       <= '0;
            x_q       <= '0;
            y_q       <= '0;
            last_q    <= 1'b0;
        end else begin
            src_hi_q  <= src_hi_d;
            dst_hi_q  <= dst_hi_d;
            src_row_q <= src_row_d;
            dst_row_q <= dst_row_d;
            src_cur_q <= src_cur_d;
            dst_cur_q <= dst_cur_d;
            w_q       <= w_d;
            h_q       <= h_d;
            x_q       <= x_d;
            y_q       <= y_d;
            last_q    <= last_d;
        end
    end

    assign src_ptr = {src_hi_q, src_cur_q};
    assign dst_ptr = {dst_hi_q, dst_cur_q};
    assign last    = last_q;

endmodule

// File: rtl/mio_blit_master.sv
// MIO bus-master blit engine: copies a picture-ROM rectangle into VRAM with optional colour key.
// Bus outputs are registered from the next-state decode so they move only on clock edges.
module mio_blit_master
    import mio_pkg::*;
#(
    parameter int RD_LAT    = 2,
    parameter int SRC_PITCH = PITCH_DEF,
    parameter int DST_PITCH = PITCH_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] src_base,
    input  logic [31:0] dst_base,
    input  logic [9:0]  blk_w,
    input  logic [8:0]  blk_h,
    input  logic        key_en,
    input  logic [11:0] key_color,
    input  logic        bus_gnt,
    input  logic [31:0] Cpu_data4bus,
    output logic        bus_req,
    output logic [31:0] addr_bus,
    output logic        mem_w,
    output logic [31:0] Cpu_data2bus,
    output logic        busy,
    output logic        done
);

    localparam int CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    blit_state_e   state_q, state_d;
    logic [CW-1:0] rd_cnt_q, rd_cnt_d;
    logic          key_en_q, key_en_d;
    logic [11:0]   key_color_q, key_color_d;
    logic          act_q, act_d, done_q, done_d, mem_w_q, mem_w_d;
    logic [31:0]   addr_q, addr_d, wdata_q, wdata_d;
    logic          load, step, last;
    logic [31:0]   src_ptr, dst_ptr;
    logic [11:0]   pix;
    logic          unused_rd_hi;

    assign pix          = Cpu_data4bus[11:0];
    assign unused_rd_hi = ^Cpu_data4bus[31:12];

    mio_blit_addr_gen #(
        .SRC_PITCH(SRC_PITCH),
        .DST_PITCH(DST_PITCH)
    ) u_addr_gen (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .step     (step),
        .src_base (src_base),
        .dst_base (dst_base),
        .blk_w    (blk_w),
        .blk_h    (blk_h),
        .src_ptr  (src_ptr),
        .dst_ptr  (dst_ptr),
        .last     (last)
    );

    always_comb begin
        state_d     = state_q;
        rd_cnt_d    = rd_cnt_q;
        key_en_d    = key_en_q;
        key_color_d = key_color_q;
        load        = 1'b0;
        step        = 1'b0;
        wdata_d     = '0;
        case (state_q)
            S_IDLE: if (start) begin
                load        = 1'b1;
                key_en_d    = key_en;
                key_color_d = key_color;
                state_d     = (blk_w == '0 || blk_h == '0) ? S_DONE : S_REQ;
            end
            S_REQ: if (bus_gnt) begin
                state_d  = S_RD;
                rd_cnt_d = '0;
            end
            S_RD: begin
                if (!bus_gnt) begin
                    state_d = S_REQ;
                end else if (rd_cnt_q == CW'(RD_LAT - 1)) begin
                    // Stepping on the way into ADV keeps the pointers ready for the next RD.
                    if (key_en_q && pix == key_color_q) begin
                        state_d = S_ADV;
                        step    = 1'b1;
                    end else begin
                        state_d = S_WR;
                        wdata_d = {20'h0, pix};
                    end
                end else begin
                    rd_cnt_d = rd_cnt_q + CW'(1);
                end
            end
            S_WR: begin
                if (!bus_gnt) begin
                    state_d = S_REQ;
                end else begin
                    state_d = S_ADV;
                    step    = 1'b1;
                end
            end
            S_ADV: begin
                if (last) begin
                    state_d = S_DONE;
                end else begin
                    state_d  = S_RD;
                    rd_cnt_d = '0;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        act_d   = (state_d == S_REQ) || (state_d == S_RD) || (state_d == S_WR) || (state_d == S_ADV);
        done_d  = (state_d == S_DONE);
        mem_w_d = (state_d == S_WR);
        addr_d  = (state_d == S_RD) ? src_ptr : (state_d == S_WR) ? dst_ptr : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            rd_cnt_q    <= '0;
            key_en_q    <= 1'b0;
            key_color_q <= '0;
            act_q       <= 1'b0;
            done_q      <= 1'b0;
            mem_w_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            rd_cnt_q    <= rd_cnt_d;
            key_en_q    <= key_en_d;
            key_color_q <= key_color_d;
            act_q       <= act_d;
            done_q      <= done_d;
            mem_w_q     <= mem_w_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
        end
    end

    // A grant withdrawn inside the WR cycle must not let the strobe reach the bus.
    assign mem_w        = mem_w_q & bus_gnt;
    assign bus_req      = act_q;
    assign busy         = act_q;
    assign addr_bus     = addr_q;
    assign Cpu_data2bus = wdata_q;
    assign done         = done_q;

endmodule
